// File: rtl/mdu_sequencer.sv
// Iterative RV32M multiply/divide unit: one bit per cycle, sign fix-up, divide fast paths.
// Define MDU_DIV_EN to build the divide datapath; otherwise divide ops complete as illegal.
module mdu_sequencer #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic            kill_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] operand_a_i,
    input  logic [XLEN-1:0] operand_b_i,
    output logic [XLEN-1:0] result_o,
    output logic            valid_o,
    output logic            busy_o,
    output logic            illegal_o
);

    localparam int unsigned CW = (XLEN > 1) ? $clog2(XLEN) : 1;
    localparam int unsigned AW = 2 * XLEN;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t            state, state_n;
    logic [CW-1:0]     cnt;
    logic [2:0]        op_q;
    logic [AW-1:0]     acc, acc_step;
    logic [XLEN-1:0]   opnd, res_q, fix_res;
    logic              sa_q, sb_q, ill_q;

    logic              accept, fast, ill, sa, sb, a_sgn, b_sgn;
    logic [XLEN-1:0]   mag_a, mag_b, fast_res;
    logic              valid_n, busy_n;

    logic [XLEN:0]     mul_sum;
    logic [AW-1:0]     mul_p;
    logic [XLEN-1:0]   mul_res;

    // Operand decode at acceptance: signedness, magnitudes, early-out results
    always_comb begin
        accept   = (state == IDLE) && start_i && !kill_i;
        a_sgn    = (op_i == 3'b001) || (op_i == 3'b010) || (op_i == 3'b100) || (op_i == 3'b110);
        b_sgn    = (op_i == 3'b001) || (op_i == 3'b100) || (op_i == 3'b110);
        sa       = a_sgn && operand_a_i[XLEN-1];
        sb       = b_sgn && operand_b_i[XLEN-1];
        mag_a    = sa ? -operand_a_i : operand_a_i;
        mag_b    = sb ? -operand_b_i : operand_b_i;
        fast     = 1'b0;
        ill      = 1'b0;
        fast_res = '0;
`ifdef MDU_DIV_EN
        if (op_i[2]) begin
            if (operand_b_i == '0) begin
                fast     = 1'b1;
                fast_res = op_i[1] ? operand_a_i : '1;
            end else if (!op_i[0] && (operand_b_i == '1) &&
                         (operand_a_i == {1'b1, {(XLEN-1){1'b0}}})) begin
                fast     = 1'b1;
                fast_res = op_i[1] ? '0 : operand_a_i;
            end
        end
`else
        fast = op_i[2];
        ill  = op_i[2];
`endif
    end

    // One iteration step; acc holds {partial, multiplier} or {remainder, quotient}
    always_comb begin
        mul_sum  = {1'b0, acc[AW-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
        acc_step = {mul_sum, acc[XLEN-1:1]};
        mul_p    = (sa_q ^ sb_q) ? -acc : acc;
        mul_res  = (op_q[1:0] == 2'b00) ? mul_p[XLEN-1:0] : mul_p[AW-1:XLEN];
        fix_res  = op_q[2] ? '0 : mul_res;
`ifdef MDU_DIV_EN
        begin
            logic [XLEN:0] trial;
            logic [XLEN-1:0] quo, rem;
            trial = {acc[AW-1:XLEN], acc[XLEN-1]} - {1'b0, opnd};
            if (op_q[2])
                acc_step = trial[XLEN] ? {acc[AW-2:0], 1'b0}
                                       : {trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
            quo = (sa_q ^ sb_q) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
            rem = sa_q ? -acc[AW-1:XLEN] : acc[AW-1:XLEN];
            if (op_q[2])
                fix_res = op_q[1] ? rem : quo;
        end
`endif
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_n;
    end

    // Next state and next registered outputs; kill aborts anything in flight
    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (accept) state_n = fast ? DONE : CALC;
            CALC: if (cnt == CW'(XLEN - 1)) state_n = FIX;
            FIX:  state_n = DONE;
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (kill_i && (state != IDLE))
            state_n = IDLE;
        valid_n = (state == DONE) && !kill_i;
        busy_n  = (state_n != IDLE) || valid_n;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt   <= '0;
            op_q  <= '0;
            acc   <= '0;
            opnd  <= '0;
            res_q <= '0;
            sa_q  <= 1'b0;
            sb_q  <= 1'b0;
            ill_q <= 1'b0;
        end else begin
            cnt <= ((state == CALC) && (state_n == CALC)) ? cnt + CW'(1) : '0;
            if (accept) begin
                op_q  <= op_i;
                sa_q  <= sa;
                sb_q  <= sb;
                ill_q <= ill;
                res_q <= fast_res;
                acc   <= {{XLEN{1'b0}}, op_i[2] ? mag_a : mag_b};
                opnd  <= op_i[2] ? mag_b : mag_a;
            end else if (state == CALC) begin
                acc <= acc_step;
            end else if (state == FIX) begin
                res_q <= fix_res;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            result_o  <= '0;
            valid_o   <= 1'b0;
            busy_o    <= 1'b0;
            illegal_o <= 1'b0;
        end else begin
            valid_o   <= valid_n;
            illegal_o <= valid_n && ill_q;
            busy_o    <= busy_n;
            if (valid_n)
                result_o <= res_q;
        end
    end

endmodule

// File: doc/mdu_sequencer.md
MDU_SEQUENCER -- requirements
Module: mdu_sequencer

Interface
REQ-001 SHALL have parameter XLEN, default 32, giving the operand and result width in bits.
REQ-002 SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_i, input, 1, synchronous active-high reset.
REQ-004 SHALL have port start_i, input, 1, request a new operation; sampled only in IDLE.
REQ-005 SHALL have port kill_i, input, 1, pipeline flush; aborts any operation in flight.
REQ-006 SHALL have port op_i, input, 3, instruction funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 SHALL have port operand_a_i, input, XLEN, rs1 value (multiplicand or dividend).
REQ-008 SHALL have port operand_b_i, input, XLEN, rs2 value (multiplier or divisor).
REQ-009 SHALL have port result_o, output, XLEN, registered result, held until the next accepted start.
REQ-010 SHALL have port valid_o, output, 1, one-cycle pulse marking result_o as new.
REQ-011 SHALL have port busy_o, output, 1, high whenever state is not IDLE; drives the pipeline stall.
REQ-012 SHALL have port illegal_o, output, 1, one-cycle pulse with valid_o for an unsupported op.

Function
REQ-013 SHALL implement the FSM states IDLE, CALC, FIX and DONE.
REQ-014 SHALL accept start_i only in IDLE with kill_i low; acceptance latches op_i and both operands. start_i outside IDLE is ignored.
REQ-015 SHALL, for a normal op, move IDLE->CALC on acceptance, stay in CALC exactly XLEN cycles (counter 0..XLEN-1), then go CALC->FIX->DONE->IDLE.
REQ-016 SHALL assert valid_o only in DONE, so valid_o rises XLEN+2 edges after the accepting edge (34 for XLEN=32).
REQ-017 SHALL process one bit per CALC cycle: shift-add for multiply, restoring subtract for divide; both use operand magnitudes, with signedness per op.
REQ-018 SHALL apply sign correction in FIX: product negated when operand signs differ (signed ops only); quotient rounds toward zero; remainder takes the dividend's sign.
REQ-019 SHALL return the low XLEN bits of the 2*XLEN product for MUL and the high XLEN bits for MULH, MULHSU and MULHU.
REQ-020 SHALL treat divide by zero as a fast path: DIV/DIVU return all-ones, REM/REMU return the dividend. The FSM goes IDLE->DONE directly, so valid_o follows 1 edge after acceptance.
REQ-021 SHALL treat signed overflow (DIV/REM, dividend = -2^(XLEN-1), divisor = -1) as the same fast path: DIV returns the dividend, REM returns 0.
REQ-022 SHALL make kill_i high in CALC, FIX or DONE go to IDLE on the next edge, with no valid_o and result_o unchanged; kill_i in DONE also suppresses that cycle's valid_o.
REQ-023 SHALL let kill_i win over start_i when both are high in IDLE: the request is not accepted.
REQ-024 SHALL keep busy_o high in DONE, so the stalled instruction captures result_o while valid_o is high.
REQ-025 SHALL accept a back-to-back start in the IDLE cycle immediately after DONE.

Reset
REQ-026 SHALL, when rst_i is high at a clock edge, set state to IDLE, the counter to 0, result_o to 0 and valid_o, busy_o and illegal_o to 0.
REQ-027 SHALL give rst_i priority over kill_i and start_i; reset mid-operation discards the operation with no valid_o.

Configuration
REQ-028 SHALL use macro MDU_DIV_EN to compile the divide datapath and the divide fast paths in or out.
REQ-029 SHALL, with MDU_DIV_EN defined, support all eight ops as specified.
REQ-030 SHALL, without MDU_DIV_EN, handle an accepted op with op_i[2]=1 as IDLE->DONE with result_o=0 and valid_o and illegal_o both high for one cycle; multiply ops are unchanged.

Verification
REQ-031 SHALL cover MUL: a=7, b=-3 -> result 0xFFFFFFEB, valid_o 34 edges after start, busy_o high throughout.
REQ-032 SHALL cover MULH and MULHU: a=0x80000000, b=0x80000000 -> MULH 0x40000000, MULHU 0x40000000; MULHSU with a=-1, b=2 -> 0xFFFFFFFF.
REQ-033 SHALL cover DIV and REM: a=-7, b=2 -> DIV 0xFFFFFFFD, REM 0xFFFFFFFF; DIVU with a=-7, b=2 -> 0x7FFFFFFC.
REQ-034 SHALL cover the fast paths: DIV a=5, b=0 -> 0xFFFFFFFF after 1 edge; REM a=0x80000000, b=-1 -> 0 after 1 edge.
REQ-035 SHALL cover kill: kill_i pulse in CALC cycle 10 -> IDLE next edge, no valid_o, prior result_o retained; then a new start completes normally.
REQ-036 SHALL cover configuration: without MDU_DIV_EN, DIVU start -> valid_o and illegal_o after 1 edge, result 0; with MDU_DIV_EN, the same op gives illegal_o=0.
